// File: rtl/mvu_pkg.sv
// MVU shared definitions: data-memory geometry, precision
// helpers and the data transposer state type.
package mvu_pkg;

    localparam int BDBANKW      = 64;
    localparam int MVU_BDBANKA  = 15;
    localparam int MVU_XPR_LEN  = 32;
    localparam int MVU_MAX_PREC = 16;

    // One-hot log2(prec) select width: prec in {1,2,4,8,16}
    localparam int PREC_SEL_W = 5;

    localparam logic [31:0] LEGAL_PREC_MASK = 32'h0001_0116;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } tr_state_e;

    function automatic logic prec_legal(input logic [31:0] p);
        return (p[31:5] == '0) && LEGAL_PREC_MASK[p[4:0]];
    endfunction

    function automatic logic [PREC_SEL_W-1:0] prec_sel(
        input logic [31:0] p
    );
        logic [PREC_SEL_W-1:0] s;
        s = '0;
        for (int i = 0; i < PREC_SEL_W; i++) begin
            s[i] = (p == 32'(1 << i));
        end
        return s;
    endfunction

endpackage

// File: rtl/mvu_bitplane_buf.sv
// Bit-plane register matrix: scatters prec-packed words into
// per-bit planes and reads back one N-bit plane at a time.
module mvu_bitplane_buf
    import mvu_pkg::*;
#(
    parameter int N        = BDBANKW,
    parameter int XPR_LEN  = MVU_XPR_LEN,
    parameter int MAX_PREC = MVU_MAX_PREC,
    parameter int WIDX_W   = 5,
    parameter int PW       = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WIDX_W-1:0]     widx,
    input  logic [PREC_SEL_W-1:0] wsel,
    input  logic [XPR_LEN-1:0]    wword,
    input  logic [PW-1:0]         rplane,
    output logic [N-1:0]          rdata
);

    logic [N-1:0] mem [MAX_PREC];

    // Element e of the block lives in word e/EPW at slot e%EPW;
    // its bit b goes to plane row b, column e.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int s = 0; s < PREC_SEL_W; s++) begin
                if (wsel[s]) begin
                    for (int e = 0; e < N; e++) begin
                        if (e / (XPR_LEN >> s) == int'(widx)) begin
                            for (int b = 0; b < (1 << s); b++) begin
                                mem[b][e] <=
                                    wword[(e % (XPR_LEN >> s)) * (1 << s) + b];
                            end
                        end
                    end
                end
            end
        end
    end

    assign rdata = mem[rplane];

endmodule

// File: rtl/mvu_data_transposer.sv
// Collects prec-packed words from the core and writes them
// to MVU data memory as MSB-first bit planes.
module mvu_data_transposer
    import mvu_pkg::*;
#(
    parameter int N        = BDBANKW,
    parameter int XPR_LEN  = MVU_XPR_LEN,
    parameter int BDBANKA  = MVU_BDBANKA,
    parameter int MAX_PREC = MVU_MAX_PREC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        prec,
    input  logic [31:0]        baddr,
    input  logic [XPR_LEN-1:0] iword,
    input  logic               start,
    output logic               busy,
    output logic               err,
    output logic               wrc_en,
    input  logic               wrc_grnt,
    output logic [BDBANKA-1:0] wrc_addr,
    output logic [N-1:0]       wrc_word
);

    localparam int PW     = $clog2(MAX_PREC);
    localparam int WIDX_W = $clog2(N * MAX_PREC / XPR_LEN);

    tr_state_e             state;
    logic [PREC_SEL_W-1:0] psel_q;
    logic [PW:0]           prec_q;
    logic [BDBANKA-1:0]    baddr_q;
    logic [WIDX_W-1:0]     wcnt;
    logic [PW-1:0]         pcnt;

    logic                  in_legal;
    logic [PREC_SEL_W-1:0] in_sel;
    logic                  buf_we;
    logic [WIDX_W-1:0]     buf_widx;
    logic [PREC_SEL_W-1:0] buf_sel;
    logic [PW:0]           ridx;
    logic [N-1:0]          plane;
    logic                  unused_hi;

    function automatic logic [WIDX_W-1:0] last_word(
        input logic [PW:0] p
    );
        return WIDX_W'((N * int'(p)) / XPR_LEN - 1);
    endfunction

    assign unused_hi = ^baddr[31:BDBANKA];
    assign in_legal  = prec_legal(prec);
    assign in_sel    = prec_sel(prec);

    assign buf_we   = start && ((state == IDLE && in_legal)
                             || state == FILL);
    assign buf_widx = (state == IDLE) ? '0 : wcnt;
    assign buf_sel  = (state == IDLE) ? in_sel : psel_q;

    // Plane 0 is the element MSB
    assign ridx     = prec_q - (PW+1)'(1) - {1'b0, pcnt};
    assign wrc_word = wrc_en ? plane : '0;

    mvu_bitplane_buf #(
        .N        (N),
        .XPR_LEN  (XPR_LEN),
        .MAX_PREC (MAX_PREC),
        .WIDX_W   (WIDX_W),
        .PW       (PW)
    ) u_buf (
        .clk    (clk),
        .we     (buf_we),
        .widx   (buf_widx),
        .wsel   (buf_sel),
        .wword  (iword),
        .rplane (ridx[PW-1:0]),
        .rdata  (plane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            psel_q   <= PREC_SEL_W'(1);
            prec_q   <= (PW+1)'(1);
            baddr_q  <= '0;
            wcnt     <= '0;
            pcnt     <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            wrc_en   <= 1'b0;
            wrc_addr <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (in_legal) begin
                            psel_q  <= in_sel;
                            prec_q  <= prec[PW:0];
                            baddr_q <= baddr[BDBANKA-1:0];
                            if (last_word(prec[PW:0]) == '0) begin
                                state    <= DRAIN;
                                busy     <= 1'b1;
                                wrc_en   <= 1'b1;
                                wrc_addr <= baddr[BDBANKA-1:0];
                                pcnt     <= '0;
                            end else begin
                                state <= FILL;
                                wcnt  <= WIDX_W'(1);
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (start) begin
                        if (wcnt == last_word(prec_q)) begin
                            state    <= DRAIN;
                            busy     <= 1'b1;
                            wrc_en   <= 1'b1;
                            wrc_addr <= baddr_q;
                            pcnt     <= '0;
                            wcnt     <= '0;
                        end else begin
                            wcnt <= wcnt + WIDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (wrc_grnt) begin
                        if ({1'b0, pcnt} == prec_q - (PW+1)'(1)) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            wrc_en <= 1'b0;
                            pcnt   <= '0;
                        end else begin
                            pcnt     <= pcnt + PW'(1);
                            wrc_addr <= wrc_addr + BDBANKA'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
